// File: rtl/board_rst_seq.sv
// Board reset sequencer: holds all domains in reset, waits for a filtered
// PLL lock, then releases domains one by one with a fixed stagger.
// Optional macro BOARD_RST_SWREQ_EN enables the software reset request in RUN.
module board_rst_seq #(
   parameter int NUM_DOMAINS = 3,
   parameter int HOLD_MIN    = 32,
   parameter int LOCK_FILT   = 16,
   parameter int STAGGER     = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   locked_i,
   input  logic                   prog_mode_i,
   input  logic                   sw_rst_req_i,
   output logic [NUM_DOMAINS-1:0] rst_no,
   output logic                   ready_o,
   output logic [1:0]             cause_o
);

   localparam int HW  = $clog2(HOLD_MIN + 1);
   localparam int FW  = $clog2(LOCK_FILT + 1);
   localparam int STW = $clog2(STAGGER + 1);
   localparam int IW  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   typedef enum logic [1:0] {
      HOLD,
      WAIT_LOCK,
      RELEASE,
      RUN
   } state_t;

   state_t                 state;
   logic [1:0]             sync;
   logic                   lk;
   logic                   prog_q;
   logic                   prog_fall;
   logic                   prog_force;
   logic                   lk_loss;
   logic                   sw_go;
   logic                   hold_req;
   logic [1:0]             hold_cause;
   logic [NUM_DOMAINS-1:0] rel;
   logic                   ready_q;
   logic [HW-1:0]          hold_cnt;
   logic [FW-1:0]          filt_cnt;
   logic [STW-1:0]         stag_cnt;
   logic [IW-1:0]          idx;

   assign lk         = sync[1];
   assign prog_fall  = prog_q & ~prog_mode_i;
   assign prog_force = prog_mode_i | prog_q;
   assign lk_loss    = ~lk & ((state == RELEASE) || (state == RUN));

`ifdef BOARD_RST_SWREQ_EN
   assign sw_go = sw_rst_req_i & (state == RUN);
`else
   logic unused_sw;
   assign unused_sw = sw_rst_req_i;
   assign sw_go     = 1'b0;
`endif

   // Return-to-HOLD request with cause priority: lock loss, prog end, software
   always_comb begin
      hold_req   = 1'b0;
      hold_cause = cause_o;
      if (lk_loss) begin
         hold_req   = 1'b1;
         hold_cause = 2'b01;
      end else if (prog_fall) begin
         hold_req   = 1'b1;
         hold_cause = 2'b10;
      end else if (sw_go) begin
         hold_req   = 1'b1;
         hold_cause = 2'b11;
      end
   end

   // Lock synchroniser, prog-mode edge detect and the sequencing FSM
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync     <= '0;
         prog_q   <= 1'b0;
         state    <= HOLD;
         rel      <= '0;
         ready_q  <= 1'b0;
         cause_o  <= 2'b00;
         hold_cnt <= '0;
         filt_cnt <= '0;
         stag_cnt <= '0;
         idx      <= '0;
      end else begin
         sync   <= {sync[0], locked_i};
         prog_q <= prog_mode_i;
         if (hold_req) begin
            state    <= HOLD;
            rel      <= '0;
            ready_q  <= 1'b0;
            cause_o  <= hold_cause;
            hold_cnt <= '0;
            filt_cnt <= '0;
            stag_cnt <= '0;
            idx      <= '0;
         end else begin
            case (state)
               HOLD: begin
                  if (hold_cnt == HW'(HOLD_MIN - 1)) begin
                     state    <= WAIT_LOCK;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               WAIT_LOCK: begin
                  if (!lk) begin
                     filt_cnt <= '0;
                  end else if (filt_cnt == FW'(LOCK_FILT - 1)) begin
                     state    <= RELEASE;
                     filt_cnt <= '0;
                     stag_cnt <= '0;
                     idx      <= '0;
                  end else begin
                     filt_cnt <= filt_cnt + 1'b1;
                  end
               end
               RELEASE: begin
                  if (stag_cnt != '0) begin
                     stag_cnt <= stag_cnt - 1'b1;
                  end else begin
                     rel[idx] <= 1'b1;
                     stag_cnt <= STW'(STAGGER - 1);
                     if (idx == IW'(NUM_DOMAINS - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
               RUN: begin
                  state <= RUN;
               end
               default: begin
                  state <= HOLD;
               end
            endcase
         end
      end
   end

   // CPU domain held in reset while programming mode is requested
   always_comb begin
      rst_no = rel;
      if (prog_force) begin
         rst_no[NUM_DOMAINS-1] = 1'b0;
      end
   end

   assign ready_o = ready_q & ~prog_force;

endmodule

// File: tb/tb_board_rst_seq.sv
// Directed testbench for board_rst_seq with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_board_rst_seq;

   logic       clk;
   logic       rst_n;
   logic       locked;
   logic       prog_mode;
   logic       sw_req;
   logic [2:0] rst_no;
   logic       ready;
   logic [1:0] cause;

   int n_checks = 0;
   int n_fail   = 0;

   board_rst_seq dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .locked_i     (locked),
      .prog_mode_i  (prog_mode),
      .sw_rst_req_i (sw_req),
      .rst_no       (rst_no),
      .ready_o      (ready),
      .cause_o      (cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Starts at the falling edge just after the edge that entered HOLD
   task automatic check_seq(input logic [1:0] exp_cause, input string tag);
      cyc(48);
      n_checks++;
      if (rst_no !== 3'b000 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_e48: rst_no=%b ready=%b expected 000/0",
                  tag, rst_no, ready);
      end
      cyc(1);
      n_checks++;
      if (rst_no !== 3'b001) begin
         n_fail++;
         $display("FAIL %s_e49: rst_no=%b expected 001", tag, rst_no);
      end
      cyc(7);
      n_checks++;
      if (rst_no !== 3'b001) begin
         n_fail++;
         $display("FAIL %s_e56: rst_no=%b expected 001", tag, rst_no);
      end
      cyc(1);
      n_checks++;
      if (rst_no !== 3'b011) begin
         n_fail++;
         $display("FAIL %s_e57: rst_no=%b expected 011", tag, rst_no);
      end
      cyc(7);
      n_checks++;
      if (rst_no !== 3'b011 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_e64: rst_no=%b ready=%b expected 011/0",
                  tag, rst_no, ready);
      end
      cyc(1);
      n_checks++;
      if (rst_no !== 3'b111 || ready !== 1'b1 || cause !== exp_cause) begin
         n_fail++;
         $display("FAIL %s_e65: rst_no=%b ready=%b cause=%b expected 111/1/%b",
                  tag, rst_no, ready, cause, exp_cause);
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      locked    = 1'b1;
      prog_mode = 1'b0;
      sw_req    = 1'b0;
      cyc(3);
      n_checks++;
      if (rst_no !== 3'b000 || ready !== 1'b0 || cause !== 2'b00) begin
         n_fail++;
         $display("FAIL reset: rst_no=%b ready=%b cause=%b expected 000/0/00",
                  rst_no, ready, cause);
      end
   endtask

   task automatic test_por;
      rst_n = 1'b1;
      check_seq(2'b00, "por");
   endtask

   task automatic test_lock_loss;
      locked = 1'b0;
      cyc(2);
      n_checks++;
      if (rst_no !== 3'b111 || ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ll_pre: rst_no=%b ready=%b expected 111/1",
                  rst_no, ready);
      end
      cyc(1);
      n_checks++;
      if (rst_no !== 3'b000 || ready !== 1'b0 || cause !== 2'b01) begin
         n_fail++;
         $display("FAIL ll_hit: rst_no=%b ready=%b cause=%b expected 000/0/01",
                  rst_no, ready, cause);
      end
      locked = 1'b1;
      check_seq(2'b01, "ll_reseq");
   endtask

   task automatic test_mid_reset;
      locked = 1'b0;
      cyc(3);
      locked = 1'b1;
      cyc(50);
      n_checks++;
      if (rst_no !== 3'b001 || cause !== 2'b01) begin
         n_fail++;
         $display("FAIL mid_pre: rst_no=%b cause=%b expected 001/01",
                  rst_no, cause);
      end
      rst_n = 1'b0;
      cyc(1);
      n_checks++;
      if (rst_no !== 3'b000 || ready !== 1'b0 || cause !== 2'b00) begin
         n_fail++;
         $display("FAIL mid_rst: rst_no=%b ready=%b cause=%b expected 000/0/00",
                  rst_no, ready, cause);
      end
      rst_n = 1'b1;
      check_seq(2'b00, "mid_reseq");
   endtask

   task automatic test_lock_filter;
      rst_n  = 1'b0;
      locked = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(34);
      locked = 1'b1;
      cyc(10);
      locked = 1'b0;
      cyc(1);
      locked = 1'b1;
      cyc(8);
      n_checks++;
      if (rst_no !== 3'b000) begin
         n_fail++;
         $display("FAIL filt_e53: rst_no=%b expected 000", rst_no);
      end
      cyc(10);
      n_checks++;
      if (rst_no !== 3'b000) begin
         n_fail++;
         $display("FAIL filt_e63: rst_no=%b expected 000", rst_no);
      end
      cyc(1);
      n_checks++;
      if (rst_no !== 3'b001 || cause !== 2'b00) begin
         n_fail++;
         $display("FAIL filt_e64: rst_no=%b cause=%b expected 001/00",
                  rst_no, cause);
      end
      cyc(16);
      n_checks++;
      if (rst_no !== 3'b111 || ready !== 1'b1) begin
         n_fail++;
         $display("FAIL filt_e80: rst_no=%b ready=%b expected 111/1",
                  rst_no, ready);
      end
   endtask

   task automatic test_prog_mode;
      prog_mode = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         n_checks++;
         if (rst_no !== 3'b011 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL prog_hold[%0d]: rst_no=%b ready=%b expected 011/0",
                     i, rst_no, ready);
         end
      end
      prog_mode = 1'b0;
      cyc(1);
      n_checks++;
      if (rst_no !== 3'b000 || ready !== 1'b0 || cause !== 2'b10) begin
         n_fail++;
         $display("FAIL prog_end: rst_no=%b ready=%b cause=%b expected 000/0/10",
                  rst_no, ready, cause);
      end
      check_seq(2'b10, "prog_reseq");
   endtask

   task automatic test_sw_req;
      sw_req = 1'b1;
      cyc(1);
      sw_req = 1'b0;
`ifdef BOARD_RST_SWREQ_EN
      n_checks++;
      if (rst_no !== 3'b000 || ready !== 1'b0 || cause !== 2'b11) begin
         n_fail++;
         $display("FAIL sw_hit: rst_no=%b ready=%b cause=%b expected 000/0/11",
                  rst_no, ready, cause);
      end
      check_seq(2'b11, "sw_reseq");
`else
      n_checks++;
      if (rst_no !== 3'b111 || ready !== 1'b1 || cause !== 2'b10) begin
         n_fail++;
         $display("FAIL sw_ign: rst_no=%b ready=%b cause=%b expected 111/1/10",
                  rst_no, ready, cause);
      end
      cyc(5);
      n_checks++;
      if (rst_no !== 3'b111 || cause !== 2'b10) begin
         n_fail++;
         $display("FAIL sw_ign_late: rst_no=%b cause=%b expected 111/10",
                  rst_no, cause);
      end
`endif
   endtask

   task automatic test_priority;
      prog_mode = 1'b1;
      cyc(4);
      locked = 1'b0;
      cyc(2);
      prog_mode = 1'b0;
      sw_req    = 1'b1;
      cyc(1);
      sw_req = 1'b0;
      locked = 1'b1;
      n_checks++;
      if (rst_no !== 3'b000 || ready !== 1'b0 || cause !== 2'b01) begin
         n_fail++;
         $display("FAIL prio: rst_no=%b ready=%b cause=%b expected 000/0/01",
                  rst_no, ready, cause);
      end
   endtask

   task automatic test_hold_restart;
      cyc(10);
      prog_mode = 1'b1;
      cyc(5);
      prog_mode = 1'b0;
      cyc(1);
      n_checks++;
      if (rst_no !== 3'b000 || cause !== 2'b10) begin
         n_fail++;
         $display("FAIL hold_rst: rst_no=%b cause=%b expected 000/10",
                  rst_no, cause);
      end
      check_seq(2'b10, "hold_restart");
   endtask

   initial begin
      test_reset();
      test_por();
      test_lock_loss();
      test_mid_reset();
      test_lock_filter();
      test_prog_mode();
      test_sw_req();
      test_priority();
      test_hold_restart();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
